hit_judge: RTL and testbench
============================

HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL provide parameter NUM_LANES, default 4: number of drum lanes, legal range 1-8.
REQ-002 SHALL provide parameter SCORE_W, default 16: score width in bits.
REQ-003 SHALL provide parameter COMBO_W, default 8: combo and max-combo width in bits.
REQ-004 SHALL provide parameter PERFECT_PTS, default 3: points per perfect hit.
REQ-005 SHALL provide parameter OKAY_PTS, default 1: points per okay hit.
REQ-006 SHALL provide parameter GHOST_MISS, default 1: 1 = a strike with no pending note counts as a miss, 0 = ignored.
REQ-007 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports: drum_level  in  NUM_LANES  drum pad level, already synchronised to clk; clear  in  1  clears score and combos.
REQ-009 SHALL have ports: note_start  in  NUM_LANES  pulse when a note enters its lane's okay window; note_expire  in  NUM_LANES  pulse when that note leaves the window.
REQ-010 SHALL have ports: lane_active_perfect  in  NUM_LANES; lane_active_okay  in  NUM_LANES  window flags.
REQ-011 SHALL have ports: hit_perfect, hit_okay, hit_miss  out  NUM_LANES each  one-cycle judgment pulses.
REQ-012 SHALL have ports: score  out  SCORE_W; combo  out  COMBO_W; max_combo  out  COMBO_W.

Function
REQ-013 SHALL detect a strike per lane as a rising edge: drum_level high now and low in the previous cycle; the previous-level register SHALL reset to all ones so a pad held through reset gives no strike.
REQ-014 SHALL run one independent FSM per lane with states IDLE (no note), ARMED (note pending, not judged) and JUDGED (note judged, waiting for expiry).
REQ-015 IDLE: note_start goes to ARMED; a strike pulses hit_miss when GHOST_MISS=1 and the state stays IDLE.
REQ-016 ARMED, on a strike: pulse hit_perfect if lane_active_perfect is high, else hit_okay if lane_active_okay is high, else hit_miss; then go to JUDGED.
REQ-017 ARMED, on note_expire with no strike: pulse hit_miss and go to IDLE.
REQ-018 JUDGED: note_expire goes to IDLE; a strike is a ghost strike and follows REQ-015; note_start goes to ARMED.
REQ-019 Strike and note_expire in the same cycle in ARMED: judge the strike per REQ-016, then go to IDLE; no extra miss.
REQ-020 note_expire and note_start in the same cycle: process the expiry first (miss if ARMED and no strike), then go to ARMED for the new note.
REQ-021 SHALL produce at most one judgment pulse per lane per cycle; at most one of the three outputs is high per lane.
REQ-022 Judgment pulses SHALL be registered and assert exactly one cycle after the strike or expiry cycle, for exactly one cycle.
REQ-023 combo SHALL update on the same clock edge as the pulses. If any lane misses in that cycle, combo becomes 0 (miss wins). Otherwise combo adds the count of perfect plus okay hits across all lanes, saturating at 2^COMBO_W-1.
REQ-024 max_combo SHALL take the new combo value whenever that value exceeds it.
REQ-025 score SHALL add PERFECT_PTS times the perfect count plus OKAY_PTS times the okay count in the same cycle, saturating at 2^SCORE_W-1. The sum SHALL be computed wide enough that it cannot overflow before saturation.
REQ-026 clear SHALL zero score, combo and max_combo on the next edge and discard that cycle's increments. clear SHALL NOT affect lane FSMs or judgment pulses.

Reset
REQ-027 On reset, all outputs SHALL be 0, all lane FSMs SHALL be IDLE and the previous-level registers SHALL be all ones.
REQ-028 Reset SHALL take priority over every input. A note ARMED when reset asserts SHALL be discarded with no miss pulse after reset releases.
REQ-029 After reset deasserts, drum_level held high SHALL produce no strike until it falls and rises again.

Verification
REQ-030 Lane 0: note_start, then a strike while perfect=1 -> hit_perfect[0] one cycle later; score=3, combo=1.
REQ-031 Lane 1: note_start, then note_expire with no strike -> hit_miss[1]; combo reset from 5 to 0; score unchanged.
REQ-032 Same cycle, strikes on lanes 0 (perfect) and 2 (okay), both ARMED -> score +4, combo +2; max_combo follows.
REQ-033 Lane 3 IDLE, strike with GHOST_MISS=1 -> hit_miss[3]; with GHOST_MISS=0 -> no pulse and combo unchanged.
REQ-034 COMBO_W=2, four consecutive perfects -> combo saturates at 3; score saturates at 0xFFFF when preloaded near its maximum.
REQ-035 Lane 0 ARMED, reset pulsed, note_expire after release -> no hit_miss; all outputs 0; drum_level held high through reset -> no strike.

Source files
------------

// File: rtl/hit_judge.sv
// Drum hit judge: per-lane note FSMs grade strikes against timing windows
// and accumulate score, combo and max combo across all lanes.
module hit_judge #(
  parameter int NUM_LANES   = 4,
  parameter int SCORE_W     = 16,
  parameter int COMBO_W     = 8,
  parameter int PERFECT_PTS = 3,
  parameter int OKAY_PTS    = 1,
  parameter int GHOST_MISS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] drum_level,
  input  logic                 clear,
  input  logic [NUM_LANES-1:0] note_start,
  input  logic [NUM_LANES-1:0] note_expire,
  input  logic [NUM_LANES-1:0] lane_active_perfect,
  input  logic [NUM_LANES-1:0] lane_active_okay,
  output logic [NUM_LANES-1:0] hit_perfect,
  output logic [NUM_LANES-1:0] hit_okay,
  output logic [NUM_LANES-1:0] hit_miss,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic [COMBO_W-1:0]   max_combo
);

  // state  | meaning
  // IDLE   | no note pending in the lane
  // ARMED  | note inside its window, not yet judged
  // JUDGED | note already judged, waiting for it to leave the window
  typedef enum logic [1:0] {IDLE, ARMED, JUDGED} lane_state_e;

  localparam int CNT_W = 4;
  localparam int SUM_W = ((SCORE_W > 40) ? SCORE_W : 40) + 2;
  localparam int CS_W  = COMBO_W + CNT_W + 1;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});
  localparam logic [CS_W-1:0]  COMBO_MAX = CS_W'({COMBO_W{1'b1}});

  lane_state_e          state_q [NUM_LANES];
  logic [NUM_LANES-1:0] level_q;
  logic [NUM_LANES-1:0] strike;
  logic [NUM_LANES-1:0] perf_d, okay_d, miss_d;
  logic [NUM_LANES-1:0] perf_q, okay_q, miss_q;
  logic [CNT_W-1:0]     n_perf, n_okay;
  logic [SUM_W-1:0]     score_sum;
  logic [CS_W-1:0]      combo_sum;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d, max_q, max_d;

  assign strike = drum_level & ~level_q;

  // A strike outside ARMED is a ghost strike.
  always_comb begin
    perf_d = '0;
    okay_d = '0;
    miss_d = '0;
    n_perf = '0;
    n_okay = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (state_q[i] == ARMED) begin
        if (strike[i]) begin
          if (lane_active_perfect[i])   perf_d[i] = 1'b1;
          else if (lane_active_okay[i]) okay_d[i] = 1'b1;
          else                          miss_d[i] = 1'b1;
        end else if (note_expire[i]) begin
          miss_d[i] = 1'b1;
        end
      end else if (strike[i] && (GHOST_MISS != 0)) begin
        miss_d[i] = 1'b1;
      end
      n_perf = n_perf + CNT_W'(perf_d[i]);
      n_okay = n_okay + CNT_W'(okay_d[i]);
    end
  end

  always_comb begin
    score_sum = SUM_W'(score_q) + SUM_W'(PERFECT_PTS) * SUM_W'(n_perf)
              + SUM_W'(OKAY_PTS) * SUM_W'(n_okay);
    combo_sum = CS_W'(combo_q) + CS_W'(n_perf) + CS_W'(n_okay);
    score_d   = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    if (|miss_d)                 combo_d = '0;
    else if (combo_sum > COMBO_MAX) combo_d = {COMBO_W{1'b1}};
    else                         combo_d = combo_sum[COMBO_W-1:0];
    max_d = (combo_d > max_q) ? combo_d : max_q;
    if (clear) begin
      score_d = '0;
      combo_d = '0;
      max_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '1;
      perf_q  <= '0;
      okay_q  <= '0;
      miss_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      for (int i = 0; i < NUM_LANES; i++) state_q[i] <= IDLE;
    end else begin
      level_q <= drum_level;
      perf_q  <= perf_d;
      okay_q  <= okay_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      // Expiry is resolved before a same-cycle note_start re-arms the lane.
      for (int i = 0; i < NUM_LANES; i++) begin
        unique case (state_q[i])
          IDLE:   if (note_start[i]) state_q[i] <= ARMED;
          ARMED: begin
            if (note_expire[i])  state_q[i] <= note_start[i] ? ARMED : IDLE;
            else if (strike[i])  state_q[i] <= JUDGED;
          end
          JUDGED: begin
            if (note_start[i])       state_q[i] <= ARMED;
            else if (note_expire[i]) state_q[i] <= IDLE;
          end
          default: state_q[i] <= IDLE;
        endcase
      end
    end
  end

  assign hit_perfect = perf_q;
  assign hit_okay    = okay_q;
  assign hit_miss    = miss_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: default build plus a no-ghost-miss build
// and a narrow combo/score build, all sharing one stimulus stream.
module tb_hit_judge;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] drum_level, note_start, note_expire, perf, okay;
  logic       clear;

  logic [3:0]  a_perf, a_okay, a_miss;
  logic [15:0] a_score;
  logic [7:0]  a_combo, a_max;
  logic [3:0]  n_perf, n_okay, n_miss;
  logic [15:0] n_score;
  logic [7:0]  n_combo, n_max;
  logic [3:0]  c_perf, c_okay, c_miss;
  logic [7:0]  c_score;
  logic [1:0]  c_combo, c_max;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hit_judge dut (
    .clk(clk), .reset(reset), .drum_level(drum_level), .clear(clear),
    .note_start(note_start), .note_expire(note_expire),
    .lane_active_perfect(perf), .lane_active_okay(okay),
    .hit_perfect(a_perf), .hit_okay(a_okay), .hit_miss(a_miss),
    .score(a_score), .combo(a_combo), .max_combo(a_max)
  );

  hit_judge #(.GHOST_MISS(0)) dut_ng (
    .clk(clk), .reset(reset), .drum_level(drum_level), .clear(clear),
    .note_start(note_start), .note_expire(note_expire),
    .lane_active_perfect(perf), .lane_active_okay(okay),
    .hit_perfect(n_perf), .hit_okay(n_okay), .hit_miss(n_miss),
    .score(n_score), .combo(n_combo), .max_combo(n_max)
  );

  hit_judge #(.COMBO_W(2), .SCORE_W(8)) dut_c2 (
    .clk(clk), .reset(reset), .drum_level(drum_level), .clear(clear),
    .note_start(note_start), .note_expire(note_expire),
    .lane_active_perfect(perf), .lane_active_okay(okay),
    .hit_perfect(c_perf), .hit_okay(c_okay), .hit_miss(c_miss),
    .score(c_score), .combo(c_combo), .max_combo(c_max)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; drum_level = 4'hF;
    note_start = '0; note_expire = '0; perf = '0; okay = '0;
    step(); step(); step();
    check("rst_pulses", {a_perf, a_okay, a_miss}, 12'h000);
    check("rst_score", a_score, 16'd0);
    check("rst_combo", {a_combo, a_max}, 16'd0);

    // pad held high across reset release must not strike
    reset = 1'b0;
    step();
    check("held_no_strike", a_miss, 4'h0);
    drum_level = 4'h0;
    step();

    // lane 0 perfect
    note_start = 4'h1; step();
    note_start = 4'h0; drum_level = 4'h1; perf = 4'h1; step();
    check("l0_perfect", a_perf, 4'h1);
    check("l0_score", a_score, 16'd3);
    check("l0_combo", a_combo, 8'd1);
    check("c2_score_a", c_score, 8'd3);
    drum_level = 4'h0; perf = 4'h0; note_expire = 4'h1; step();
    check("l0_one_cycle", a_perf, 4'h0);
    note_expire = 4'h0;

    // simultaneous perfect lane 0 and okay lane 2 (perfect wins on lane 0)
    note_start = 4'h5; step();
    note_start = 4'h0; drum_level = 4'h5; perf = 4'h1; okay = 4'h5; step();
    check("dual_perf", a_perf, 4'h1);
    check("dual_okay", a_okay, 4'h4);
    check("dual_score", a_score, 16'd7);
    check("dual_combo", {a_combo, a_max}, {8'd3, 8'd3});
    drum_level = 4'h0; perf = 4'h0; okay = 4'h0; note_expire = 4'h5; step();
    note_expire = 4'h0;

    clear = 1'b1; step(); clear = 1'b0;
    check("clear", {a_score, a_combo, a_max}, 32'd0);

    // build combo to 5, then miss on lane 1
    note_start = 4'hF; step();
    note_start = 4'h0; drum_level = 4'hF; perf = 4'hF; step();
    check("four_combo", a_combo, 8'd4);
    check("four_score", a_score, 16'd12);
    check("c2_combo_sat", c_combo, 2'd3);
    drum_level = 4'h0; perf = 4'h0; note_expire = 4'hF; step();
    note_expire = 4'h0; note_start = 4'h1; step();
    note_start = 4'h0; drum_level = 4'h1; okay = 4'h1; step();
    check("okay_l0", a_okay, 4'h1);
    check("combo5", {a_combo, a_max}, {8'd5, 8'd5});
    check("score13", a_score, 16'd13);
    drum_level = 4'h0; okay = 4'h0; note_expire = 4'h1; step();
    note_expire = 4'h0; note_start = 4'h2; step();
    note_start = 4'h0; note_expire = 4'h2; step();
    check("expire_miss", a_miss, 4'h2);
    check("miss_combo", {a_combo, a_max}, {8'd0, 8'd5});
    check("miss_score", a_score, 16'd13);
    note_expire = 4'h0;

    // ghost strike on idle lane 3
    note_start = 4'h1; step();
    note_start = 4'h0; drum_level = 4'h1; perf = 4'h1; step();
    drum_level = 4'h0; perf = 4'h0; note_expire = 4'h1; step();
    note_expire = 4'h0; drum_level = 4'h8; step();
    check("ghost_miss", a_miss, 4'h8);
    check("ghost_combo", a_combo, 8'd0);
    check("noghost_miss", n_miss, 4'h0);
    check("noghost_combo", n_combo, 8'd1);
    check("noghost_score", n_score, 16'd16);
    drum_level = 4'h0; step();

    // strike and expiry together while armed: judged, no extra miss
    note_start = 4'h4; step();
    note_start = 4'h0; drum_level = 4'h4; okay = 4'h4; note_expire = 4'h4; step();
    check("same_cyc_okay", {a_okay, a_miss}, {4'h4, 4'h0});
    drum_level = 4'h0; okay = 4'h0; note_expire = 4'h0; step();
    check("same_cyc_nomiss", {a_okay, a_miss}, 8'h00);

    // expiry and new note together: miss first, then re-armed
    note_start = 4'h4; step();
    note_expire = 4'h4; step();
    check("exp_start_miss", a_miss, 4'h4);
    note_start = 4'h0; note_expire = 4'h0; drum_level = 4'h4; perf = 4'h4; step();
    check("rearm_perfect", a_perf, 4'h4);
    check("rearm_score", a_score, 16'd20);
    check("rearm_combo", a_combo, 8'd1);
    drum_level = 4'h0; perf = 4'h0; note_expire = 4'h4; step();
    note_expire = 4'h0;

    // reset while armed discards the note
    note_start = 4'h1; step();
    note_start = 4'h0; reset = 1'b1; drum_level = 4'hF; step(); step();
    check("rst2_outs", {a_score, a_combo, a_max}, 32'd0);
    reset = 1'b0; note_expire = 4'h1; step();
    check("rst2_no_miss", {a_perf, a_okay, a_miss}, 12'h000);
    note_expire = 4'h0; step();
    check("rst2_no_strike", {a_perf, a_okay, a_miss}, 12'h000);
    drum_level = 4'h0; step();

    // long run of perfects to saturate score and combo
    note_start = 4'hF; step();
    for (int k = 0; k < 5462; k++) begin
      note_start = 4'h0; drum_level = 4'hF; perf = 4'hF; step();
      note_start = 4'hF; drum_level = 4'h0; perf = 4'h0; step();
    end
    check("score_sat", a_score, 16'hFFFF);
    check("combo_sat", {a_combo, a_max}, {8'hFF, 8'hFF});
    check("c2_score_sat", c_score, 8'hFF);
    check("c2_combo_sat2", {c_combo, c_max}, {2'd3, 2'd3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
